// File: rtl/clk_en_gen_pkg.sv
// clk_en_gen_pkg: shared types and helpers for the fractional clock-enable
// generator.
//   state_t    - configuration FSM states (IDLE, SETTLE, LOCKED)
//   ch_cfg_t   - one channel's settings {num, den, phase}; fields are sized to
//                CFG_W_MAX and carry ACC_W-bit values zero-extended
//   cfg_ok()   - validity check applied to every channel at commit
package clk_en_gen_pkg;

  localparam int unsigned CFG_W_MAX = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_LOCKED
  } state_t;

  typedef struct packed {
    logic [CFG_W_MAX-1:0] num;
    logic [CFG_W_MAX-1:0] den;
    logic [CFG_W_MAX-1:0] phase;
  } ch_cfg_t;

  // A disabled channel (num == 0) is always acceptable; an enabled one must
  // wrap at most once per cycle and start inside the modulus.
  function automatic logic cfg_ok(input ch_cfg_t c);
    return (c.num == '0) || ((c.num < c.den) && (c.phase < c.den));
  endfunction

endpackage

// File: rtl/clk_en_nco.sv
// clk_en_nco: one channel of the fractional enable generator.
// Bresenham accumulator: every cycle acc += num; on reaching den the
// accumulator wraps (acc -= den) and a one-cycle ce strobe is registered.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   load         - commit accepted this edge: acc <= load_phase, ce <= 0
//   load_phase   - starting accumulator value for the new configuration
//   num, den     - active increment / modulus (num == 0 freezes the channel)
//   ce           - registered enable strobe
//   lvl          - (CLK_EN_GEN_LEVEL_EN only) toggles on every strobe
module clk_en_nco #(
  parameter int unsigned ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [ACC_W-1:0] load_phase,
  input  logic [ACC_W-1:0] num,
  input  logic [ACC_W-1:0] den,
  output logic             ce
`ifdef CLK_EN_GEN_LEVEL_EN
  ,
  output logic             lvl
`endif
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum;
  logic [ACC_W:0]   diff;
  logic             wrap;

  // One extra bit keeps acc + num exact; num < den guarantees a single wrap.
  always_comb begin
    sum  = {1'b0, acc} + {1'b0, num};
    diff = sum - {1'b0, den};
    wrap = (num != '0) && (sum >= {1'b0, den});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      ce  <= 1'b0;
    end else if (load) begin
      acc <= load_phase;
      ce  <= 1'b0;
    end else if (num != '0) begin
      acc <= wrap ? diff[ACC_W-1:0] : sum[ACC_W-1:0];
      ce  <= wrap;
    end else begin
      ce  <= 1'b0;
    end
  end

`ifdef CLK_EN_GEN_LEVEL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl <= 1'b0;
    end else if (load) begin
      lvl <= 1'b0;
    end else if (wrap) begin
      lvl <= ~lvl;
    end
  end
`endif

endmodule

// File: rtl/clk_en_gen.sv
// clk_en_gen: multi-channel fractional clock-enable generator.
// Each channel strobes ce[i] at an average rate of num/den of clk, starting
// from a programmable accumulator phase. Settings are written into shadow
// registers and applied to all channels at once by a validated commit;
// `locked` reports that the configuration has settled.
// Optional feature macro: CLK_EN_GEN_LEVEL_EN adds clk_lvl, a per-channel
// level that toggles on every strobe (rate num/(2*den)).
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   cfg_valid/cfg_ready   - shadow write handshake (ready low while settling)
//   cfg_ch                - target channel; out-of-range writes are ignored
//   cfg_num/den/phase     - channel settings (num == 0 disables the channel)
//   cfg_commit            - apply all shadow settings (accepted when ready)
//   cfg_err               - one-cycle pulse: commit rejected, nothing changed
//   ce                    - per-channel enable strobes
//   locked                - configuration applied and settled
//   clk_lvl               - (CLK_EN_GEN_LEVEL_EN only) divided levels
module clk_en_gen
  import clk_en_gen_pkg::*;
#(
  parameter  int unsigned CHANNELS      = 4,
  parameter  int unsigned ACC_W         = 24,
  parameter  int unsigned SETTLE_CYCLES = 16,
  localparam int unsigned CH_W          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [ACC_W-1:0]    cfg_num,
  input  logic [ACC_W-1:0]    cfg_den,
  input  logic [ACC_W-1:0]    cfg_phase,
  input  logic                cfg_commit,
  output logic                cfg_err,
  output logic [CHANNELS-1:0] ce,
  output logic                locked
`ifdef CLK_EN_GEN_LEVEL_EN
  ,
  output logic [CHANNELS-1:0] clk_lvl
`endif
);

  localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] settle_cnt;

  ch_cfg_t shadow     [CHANNELS];
  ch_cfg_t shadow_nxt [CHANNELS];
  ch_cfg_t active     [CHANNELS];

  logic wr_en;
  logic all_ok;
  logic commit_ok;
  logic commit_bad;

  assign cfg_ready = (state != ST_SETTLE);
  assign locked    = (state == ST_LOCKED);
  assign wr_en     = cfg_valid && cfg_ready && (32'(cfg_ch) < CHANNELS);

  // The commit validates the shadow set including a write on the same edge.
  always_comb begin
    shadow_nxt = shadow;
    if (wr_en) begin
      shadow_nxt[cfg_ch] = '{num:   CFG_W_MAX'(cfg_num),
                             den:   CFG_W_MAX'(cfg_den),
                             phase: CFG_W_MAX'(cfg_phase)};
    end
    all_ok = 1'b1;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      all_ok = all_ok && cfg_ok(shadow_nxt[i]);
    end
  end

  assign commit_ok  = cfg_commit && cfg_ready && all_ok;
  assign commit_bad = cfg_commit && cfg_ready && !all_ok;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (commit_ok) state_nxt = ST_SETTLE;
      ST_SETTLE: if (settle_cnt == CNT_W'(SETTLE_CYCLES - 1)) state_nxt = ST_LOCKED;
      ST_LOCKED: if (commit_ok) state_nxt = ST_SETTLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      cfg_err    <= 1'b0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      state   <= state_nxt;
      cfg_err <= commit_bad;
      shadow  <= shadow_nxt;
      if (commit_ok) begin
        active     <= shadow_nxt;
        settle_cnt <= '0;
      end else if (state == ST_SETTLE) begin
        settle_cnt <= settle_cnt + 1'b1;
      end
    end
  end

  // The accumulator loads its phase straight from the commit-time shadow
  // value, so the active phase copy and the zero-extension bits are never
  // read back.
  logic unused_bits;
  always_comb begin
    unused_bits = 1'b0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      unused_bits = unused_bits ^ (^active[i].phase)
                                ^ (^(active[i].num >> ACC_W))
                                ^ (^(active[i].den >> ACC_W));
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    clk_en_nco #(
      .ACC_W(ACC_W)
    ) u_nco (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (commit_ok),
      .load_phase (shadow_nxt[g].phase[ACC_W-1:0]),
      .num        (active[g].num[ACC_W-1:0]),
      .den        (active[g].den[ACC_W-1:0]),
      .ce         (ce[g])
`ifdef CLK_EN_GEN_LEVEL_EN
      ,
      .lvl        (clk_lvl[g])
`endif
    );
  end

endmodule

// File: tb/tb_clk_en_gen.sv
// tb_clk_en_gen: self-checking bench for clk_en_gen.
// The driver applies one input set per clock, advances a reference model of
// the configuration rules and pushes the expected post-edge outputs into a
// queue; a monitor on the falling edge pops and compares. Channel strobes are
// predicted in closed form: with k edges since the commit, the channel has
// wrapped floor((phase + k*num)/den) times, and ce is high when that count
// just changed.
module tb_clk_en_gen;

  localparam int unsigned CHANNELS      = 4;
  localparam int unsigned ACC_W         = 24;
  localparam int unsigned SETTLE_CYCLES = 16;
  localparam int unsigned CH_W          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                cfg_valid = 1'b0;
  logic                cfg_ready;
  logic [CH_W-1:0]     cfg_ch = '0;
  logic [ACC_W-1:0]    cfg_num = '0;
  logic [ACC_W-1:0]    cfg_den = '0;
  logic [ACC_W-1:0]    cfg_phase = '0;
  logic                cfg_commit = 1'b0;
  logic                cfg_err;
  logic [CHANNELS-1:0] ce;
  logic                locked;
`ifdef CLK_EN_GEN_LEVEL_EN
  logic [CHANNELS-1:0] clk_lvl;
`endif

  always #5 clk = ~clk;

  clk_en_gen #(
    .CHANNELS      (CHANNELS),
    .ACC_W         (ACC_W),
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ch     (cfg_ch),
    .cfg_num    (cfg_num),
    .cfg_den    (cfg_den),
    .cfg_phase  (cfg_phase),
    .cfg_commit (cfg_commit),
    .cfg_err    (cfg_err),
    .ce         (ce),
    .locked     (locked)
`ifdef CLK_EN_GEN_LEVEL_EN
    ,
    .clk_lvl    (clk_lvl)
`endif
  );

  typedef struct {
    logic [CHANNELS-1:0] ce;
    logic [CHANNELS-1:0] lvl;
    logic                locked;
    logic                ready;
    logic                err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, want);
    end
  endtask

  // ---------------- reference model ----------------
  longint m_sh_num [CHANNELS];
  longint m_sh_den [CHANNELS];
  longint m_sh_ph  [CHANNELS];
  longint m_ac_num [CHANNELS];
  longint m_ac_den [CHANNELS];
  longint m_ac_ph  [CHANNELS];
  bit     m_committed;
  longint m_k;
  bit     m_err;

  task automatic model_reset();
    for (int i = 0; i < CHANNELS; i++) begin
      m_sh_num[i] = 0; m_sh_den[i] = 0; m_sh_ph[i] = 0;
      m_ac_num[i] = 0; m_ac_den[i] = 0; m_ac_ph[i] = 0;
    end
    m_committed = 0;
    m_k         = 0;
    m_err       = 0;
  endtask

  function automatic bit model_ready();
    return !m_committed || (m_k >= longint'(SETTLE_CYCLES));
  endfunction

  function automatic longint wraps(input int ch, input longint k);
    if (m_ac_num[ch] == 0) return 0;
    return (m_ac_ph[ch] + k * m_ac_num[ch]) / m_ac_den[ch];
  endfunction

  task automatic model_edge(input bit v, input int ch, input longint n,
                            input longint d, input longint p, input bit c);
    bit rdy;
    bit ok;
    rdy = model_ready();
    if (v && rdy && ch < CHANNELS) begin
      m_sh_num[ch] = n; m_sh_den[ch] = d; m_sh_ph[ch] = p;
    end
    ok = 1;
    for (int i = 0; i < CHANNELS; i++)
      if (m_sh_num[i] != 0 && !(m_sh_num[i] < m_sh_den[i] && m_sh_ph[i] < m_sh_den[i]))
        ok = 0;
    m_err = c && rdy && !ok;
    if (c && rdy && ok) begin
      for (int i = 0; i < CHANNELS; i++) begin
        m_ac_num[i] = m_sh_num[i]; m_ac_den[i] = m_sh_den[i]; m_ac_ph[i] = m_sh_ph[i];
      end
      m_committed = 1;
      m_k         = 0;
    end else if (m_committed) begin
      m_k++;
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    for (int i = 0; i < CHANNELS; i++) begin
      e.ce[i]  = m_committed && (m_k >= 1) && (wraps(i, m_k) != wraps(i, m_k - 1));
      e.lvl[i] = m_committed && (wraps(i, m_k) % 2 == 1);
    end
    e.locked = m_committed && (m_k >= longint'(SETTLE_CYCLES));
    e.ready  = model_ready();
    e.err    = m_err;
    return e;
  endfunction

  // ---------------- driver ----------------
  task automatic step(input bit v = 0, input int ch = 0, input longint n = 0,
                      input longint d = 0, input longint p = 0, input bit c = 0);
    cfg_valid  = v;
    cfg_ch     = ch[CH_W-1:0];
    cfg_num    = n[ACC_W-1:0];
    cfg_den    = d[ACC_W-1:0];
    cfg_phase  = p[ACC_W-1:0];
    cfg_commit = c;
    @(posedge clk);
    model_edge(v, ch, n, d, p, c);
    sb.push_back(model_out());
    #1;
    cfg_valid  = 1'b0;
    cfg_commit = 1'b0;
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) step();
  endtask

  task automatic rand_cfg(output longint n, output longint d, output longint p);
    if ($urandom_range(0, 7) == 0) begin
      d = 64'hFFFFFF;
      n = d - longint'($urandom_range(0, 3));
      p = d - longint'($urandom_range(0, 2));
    end else begin
      d = $urandom_range(1, 40);
      n = $urandom_range(0, 32'(d));
      p = $urandom_range(0, 32'(d));
    end
  endtask

  task automatic wait_negedge();
    @(negedge clk);
    #1;
  endtask

  // ---------------- monitor ----------------
  int     str_cnt [CHANNELS];
  longint mon_cyc = 0;
  longint last0   = -1;
  longint gmin    = 0;
  longint gmax    = 0;

  task automatic clear_stats();
    for (int i = 0; i < CHANNELS; i++) str_cnt[i] = 0;
    last0 = -1;
    gmin  = 1000000;
    gmax  = 0;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("ce", longint'(ce), longint'(mon_e.ce));
      chk("locked", longint'(locked), longint'(mon_e.locked));
      chk("cfg_ready", longint'(cfg_ready), longint'(mon_e.ready));
      chk("cfg_err", longint'(cfg_err), longint'(mon_e.err));
`ifdef CLK_EN_GEN_LEVEL_EN
      chk("clk_lvl", longint'(clk_lvl), longint'(mon_e.lvl));
`endif
      for (int i = 0; i < CHANNELS; i++) if (ce[i]) str_cnt[i]++;
      if (ce[0]) begin
        if (last0 >= 0) begin
          if (mon_cyc - last0 < gmin) gmin = mon_cyc - last0;
          if (mon_cyc - last0 > gmax) gmax = mon_cyc - last0;
        end
        last0 = mon_cyc;
      end
      mon_cyc++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    longint n, d, p;
    int ch;

    model_reset();
    clear_stats();

    // Reset values while reset is held.
    #3;
    chk("rst_ce", longint'(ce), 0);
    chk("rst_locked", longint'(locked), 0);
    chk("rst_ready", longint'(cfg_ready), 1);
    chk("rst_err", longint'(cfg_err), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    idle(3);

    // Commit with every channel disabled: settles, locks, never strobes.
    step(0, 0, 0, 0, 0, 1);
    idle(SETTLE_CYCLES + 4);

    // ch0 1/4 phase 0, ch1 1/4 phase 3 (written on the commit edge).
    step(1, 0, 1, 4, 0, 0);
    step(1, 1, 1, 4, 3, 1);
    clear_stats();
    idle(100);
    wait_negedge();
    chk("ch0_cnt_100", str_cnt[0], 25);
    chk("ch1_cnt_100", str_cnt[1], 25);

    // ch0 3/10 over 1000 cycles.
    step(1, 0, 3, 10, 0, 1);
    clear_stats();
    idle(1000);
    wait_negedge();
    chk("ch0_cnt_1000", str_cnt[0], 300);
    chk("ch0_gap_min", gmin, 3);
    chk("ch0_gap_max", gmax, 4);

    // ch2 num == den: rejected, state and locked untouched.
    step(1, 2, 5, 5, 0, 1);
    idle(5);
    step(1, 2, 0, 0, 0, 0);
    idle(3);

    // Recommit mid-stream while locked; writes and commits during settle drop.
    step(1, 0, 3, 8, 2, 1);
    step(1, 3, 1, 2, 0, 0);
    step(1, 1, 7, 7, 0, 1);
    idle(SETTLE_CYCLES + 4);

    // Randomized configuration traffic.
    repeat (12) begin
      repeat ($urandom_range(1, 4)) begin
        ch = $urandom_range(0, CHANNELS - 1);
        rand_cfg(n, d, p);
        step(1, ch, n, d, p, 0);
      end
      step(0, 0, 0, 0, 0, 1);
      repeat ($urandom_range(5, 60)) begin
        case ($urandom_range(0, 9))
          0: begin
            ch = $urandom_range(0, CHANNELS - 1);
            rand_cfg(n, d, p);
            step(1, ch, n, d, p, 0);
          end
          1: step(0, 0, 0, 0, 0, 1);
          default: step();
        endcase
      end
    end

    // Clean set, commit, then reset in the middle of settling.
    for (int i = 0; i < CHANNELS; i++) step(1, i, 1, 3, 0, 0);
    idle(SETTLE_CYCLES + 2);
    step(0, 0, 0, 0, 0, 1);
    idle(5);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ce", longint'(ce), 0);
    chk("arst_locked", longint'(locked), 0);
    chk("arst_ready", longint'(cfg_ready), 1);
    chk("arst_err", longint'(cfg_err), 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    idle(30);

    // Fresh commit after reset brings channels back.
    step(1, 0, 1, 4, 3, 1);
    idle(SETTLE_CYCLES + 10);

    wait_negedge();
    chk("sb_drained", longint'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
